// File: rtl/cla_operand_feeder.sv
// Operand FIFO and registered issue stage feeding the 8-bit clocked CLA adder.
// Optional macro CLA_FEED_STATS_EN adds a saturating 16-bit issued_cnt output.
module cla_operand_feeder #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             flush,
    output logic             op_valid,
    input  logic             op_ready,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic             op_cin,
    output logic [AW:0]      level,
    output logic             full,
    output logic             empty
`ifdef CLA_FEED_STATS_EN
    ,
    output logic [15:0]      issued_cnt
`endif
);

    localparam int EW = 2 * WIDTH + 1;

    typedef enum logic {S_EMPTY, S_HOLD} state_t;

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    state_t        state, state_nx;
    logic          wr_en, ld_en;

    assign full     = (level == (AW + 1)'(DEPTH));
    assign empty    = (level == '0);
    assign in_ready = !full;
    assign op_valid = (state == S_HOLD);

    always_comb begin
        wr_en    = in_valid && !full && !flush;
        ld_en    = !flush && (!op_valid || op_ready) && !empty;
        state_nx = state;
        if (flush)
            state_nx = S_EMPTY;
        else if (ld_en)
            state_nx = S_HOLD;
        else if (op_ready)
            state_nx = S_EMPTY;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_EMPTY;
        else
            state <= state_nx;
    end

    // Storage is not reset; level/pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= {in_a, in_b, in_cin};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + AW'(1);
            if (ld_en)
                rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, ld_en})
                2'b10:   level <= level + (AW + 1)'(1);
                2'b01:   level <= level - (AW + 1)'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a   <= '0;
            op_b   <= '0;
            op_cin <= 1'b0;
        end else if (ld_en) begin
            {op_a, op_b, op_cin} <= mem[rd_ptr];
        end
    end

`ifdef CLA_FEED_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            issued_cnt <= '0;
        else if (op_valid && op_ready && issued_cnt != '1)
            issued_cnt <= issued_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_cla_operand_feeder.sv
// Directed self-checking bench for cla_operand_feeder.
module tb_cla_operand_feeder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a, in_b;
    logic       in_cin;
    logic       flush;
    logic       op_valid;
    logic       op_ready;
    logic [7:0] op_a, op_b;
    logic       op_cin;
    logic [2:0] level;
    logic       full, empty;
`ifdef CLA_FEED_STATS_EN
    logic [15:0] issued_cnt;
`endif

    int total = 0;
    int bad   = 0;

    cla_operand_feeder #(.WIDTH(8), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
        .flush(flush),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_a(op_a), .op_b(op_b), .op_cin(op_cin),
        .level(level), .full(full), .empty(empty)
`ifdef CLA_FEED_STATS_EN
        , .issued_cnt(issued_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b, input logic c);
        in_valid = v;
        in_a     = a;
        in_b     = b;
        in_cin   = c;
    endtask

    task automatic test_reset();
        total++; if (level !== 3'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", level); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", empty); end
        total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", full); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        total++; if (op_valid !== 1'b0) begin bad++; $display("FAIL reset_op_valid got=%b exp=0", op_valid); end
        total++; if ({op_a, op_b, op_cin} !== 17'd0) begin bad++; $display("FAIL reset_op got=%h exp=0", {op_a, op_b, op_cin}); end
    endtask

    task automatic test_single();
        logic [8:0] res;
        op_ready = 1'b1;
        drive(1'b1, 8'd24, 8'd1, 1'b1);
        tick();
        drive(1'b0, 8'd0, 8'd0, 1'b0);
        total++; if (op_valid !== 1'b0) begin bad++; $display("FAIL single_no_bypass got=%b exp=0", op_valid); end
        total++; if (level !== 3'd1) begin bad++; $display("FAIL single_level1 got=%0d exp=1", level); end
        tick();
        total++; if (op_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", op_valid); end
        total++; if ({op_a, op_b, op_cin} !== {8'd24, 8'd1, 1'b1}) begin bad++; $display("FAIL single_data got=%0d,%0d,%0d exp=24,1,1", op_a, op_b, op_cin); end
        res = {1'b0, op_a} + {1'b0, op_b} + {8'd0, op_cin};
        total++; if (res !== 9'd26) begin bad++; $display("FAIL single_adder_result got=%0d exp=26", res); end
        tick();
        total++; if (op_valid !== 1'b0 || empty !== 1'b1) begin bad++; $display("FAIL single_drained got=v%b e%b exp=v0 e1", op_valid, empty); end
    endtask

    logic [16:0] fill_vec [5];

    task automatic test_fill();
        fill_vec[0] = {8'd0, 8'd0, 1'b1};
        fill_vec[1] = {8'd5, 8'd7, 1'b0};
        fill_vec[2] = {8'd9, 8'd9, 1'b1};
        fill_vec[3] = {8'd1, 8'd2, 1'b0};
        fill_vec[4] = {8'd3, 8'd3, 1'b1};
        op_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, fill_vec[i][16:9], fill_vec[i][8:1], fill_vec[i][0]);
            tick();
        end
        total++; if ({op_valid, op_a, op_b, op_cin} !== {1'b1, fill_vec[0]}) begin bad++; $display("FAIL fill_head_in_op got=%h exp=%h", {op_valid, op_a, op_b, op_cin}, {1'b1, fill_vec[0]}); end
        total++; if (level !== 3'd4) begin bad++; $display("FAIL fill_level got=%0d exp=4", level); end
        total++; if (full !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("FAIL fill_full got=f%b r%b exp=f1 r0", full, in_ready); end
        drive(1'b1, 8'd7, 8'd7, 1'b0);
        tick();
        drive(1'b0, 8'd0, 8'd0, 1'b0);
        total++; if (level !== 3'd4) begin bad++; $display("FAIL fill_refused_level got=%0d exp=4", level); end
        total++; if ({op_a, op_b, op_cin} !== fill_vec[0]) begin bad++; $display("FAIL fill_refused_data got=%h exp=%h", {op_a, op_b, op_cin}, fill_vec[0]); end
    endtask

    task automatic test_drain();
        op_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            total++;
            if ({op_valid, op_a, op_b, op_cin} !== {1'b1, fill_vec[i]}) begin
                bad++;
                $display("FAIL drain_order[%0d] got=%h exp=%h", i, {op_valid, op_a, op_b, op_cin}, {1'b1, fill_vec[i]});
            end
            tick();
        end
        total++; if (op_valid !== 1'b0 || empty !== 1'b1 || level !== 3'd0) begin bad++; $display("FAIL drain_end got=v%b e%b l%0d exp=v0 e1 l0", op_valid, empty, level); end
    endtask

    task automatic test_stall();
        op_ready = 1'b0;
        drive(1'b1, 8'd9, 8'd9, 1'b1); tick();
        drive(1'b1, 8'd4, 8'd5, 1'b0); tick();
        drive(1'b1, 8'd6, 8'd6, 1'b1); tick();
        drive(1'b0, 8'd0, 8'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({op_valid, op_a, op_b, op_cin} !== {1'b1, 8'd9, 8'd9, 1'b1}) begin
                bad++;
                $display("FAIL stall_hold[%0d] got=%h exp=%h", i, {op_valid, op_a, op_b, op_cin}, {1'b1, 8'd9, 8'd9, 1'b1});
            end
            tick();
        end
        op_ready = 1'b1;
        tick();
        total++; if ({op_valid, op_a, op_b, op_cin} !== {1'b1, 8'd4, 8'd5, 1'b0}) begin bad++; $display("FAIL stall_adv1 got=%h exp=%h", {op_valid, op_a, op_b, op_cin}, {1'b1, 8'd4, 8'd5, 1'b0}); end
        tick();
        total++; if ({op_valid, op_a, op_b, op_cin} !== {1'b1, 8'd6, 8'd6, 1'b1}) begin bad++; $display("FAIL stall_adv2 got=%h exp=%h", {op_valid, op_a, op_b, op_cin}, {1'b1, 8'd6, 8'd6, 1'b1}); end
        tick();
        total++; if (op_valid !== 1'b0) begin bad++; $display("FAIL stall_end got=%b exp=0", op_valid); end
    endtask

    task automatic test_flush();
        op_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'(10 + i), 8'(20 + i), 1'b0);
            tick();
        end
        total++; if (level !== 3'd3 || op_valid !== 1'b1) begin bad++; $display("FAIL flush_setup got=l%0d v%b exp=l3 v1", level, op_valid); end
        drive(1'b1, 8'd200, 8'd100, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 8'd0, 8'd0, 1'b0);
        total++; if (level !== 3'd0 || op_valid !== 1'b0 || empty !== 1'b1) begin bad++; $display("FAIL flush_clear got=l%0d v%b e%b exp=l0 v0 e1", level, op_valid, empty); end
        op_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (op_valid !== 1'b0 || level !== 3'd0) begin
                bad++;
                $display("FAIL flush_dropped[%0d] got=v%b l%0d exp=v0 l0", i, op_valid, level);
            end
        end
    endtask

    task automatic test_async_reset();
        op_ready = 1'b0;
        drive(1'b1, 8'd11, 8'd12, 1'b1); tick();
        drive(1'b1, 8'd13, 8'd14, 1'b0); tick();
        drive(1'b1, 8'd15, 8'd16, 1'b1); tick();
        drive(1'b0, 8'd0, 8'd0, 1'b0);
        total++; if (level !== 3'd2 || op_valid !== 1'b1) begin bad++; $display("FAIL areset_setup got=l%0d v%b exp=l2 v1", level, op_valid); end
        #2 rst_n = 1'b0;
        #1;
        test_reset();
`ifdef CLA_FEED_STATS_EN
        total++; if (issued_cnt !== 16'd0) begin bad++; $display("FAIL areset_issued_cnt got=%0d exp=0", issued_cnt); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        op_ready = 1'b1;
        drive(1'b1, 8'd24, 8'd1, 1'b1);
        tick();
        drive(1'b0, 8'd0, 8'd0, 1'b0);
        tick();
        total++; if ({op_valid, op_a, op_b, op_cin} !== {1'b1, 8'd24, 8'd1, 1'b1}) begin bad++; $display("FAIL areset_post_write got=%h exp=%h", {op_valid, op_a, op_b, op_cin}, {1'b1, 8'd24, 8'd1, 1'b1}); end
    endtask

    initial begin
        rst_n    = 1'b0;
        flush    = 1'b0;
        op_ready = 1'b0;
        drive(1'b0, 8'd0, 8'd0, 1'b0);
        #12;
        test_reset();
        rst_n = 1'b1;
        tick();
        test_single();
        test_fill();
        test_drain();
        test_stall();
        test_flush();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
